// File: rtl/hier_fanout_if.sv
// Parent/child handshake bundle for one hier_fanout_node.
// The slave view belongs to the node; the master view belongs to whatever sits
// around it: the parent driving commands and the children answering them.
interface hier_fanout_if #(
    parameter int NUM_CHILDREN = 10,
    parameter int DATA_W       = 8
);
    logic                    up_valid;
    logic                    up_ready;
    logic [DATA_W-1:0]       up_data;
    logic                    up_done;
    logic                    up_err;
    logic [NUM_CHILDREN-1:0] fail_mask;
    logic [NUM_CHILDREN-1:0] dn_valid;
    logic [DATA_W-1:0]       dn_data;
    logic [NUM_CHILDREN-1:0] dn_ready;
    logic [NUM_CHILDREN-1:0] dn_done;

    modport master (
        output up_valid, up_data, dn_ready, dn_done,
        input  up_ready, up_done, up_err, fail_mask, dn_valid, dn_data
    );

    modport slave (
        input  up_valid, up_data, dn_ready, dn_done,
        output up_ready, up_done, up_err, fail_mask, dn_valid, dn_data
    );
endinterface

// File: rtl/hier_fanout_node.sv
// Hierarchy fan-out node: accepts one command from its parent and distributes
// it to NUM_CHILDREN children, either to all children at once (broadcast) or
// to one child at a time in ascending index order (sequential). Per-child
// completions are gathered into a single done/error pulse back to the parent.
// A timeout aborts a stuck transaction and reports the unfinished children.
module hier_fanout_node #(
    parameter int NUM_CHILDREN = 10,
    parameter int DATA_W       = 8,
    parameter int SEQ_MODE     = 0,
    parameter int TIMEOUT_CYC  = 255,
    parameter int CNT_W        = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    hier_fanout_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam int IDX_W = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1;
    localparam logic [NUM_CHILDREN-1:0] ALL_ONES    = '1;
    localparam logic [IDX_W-1:0]        LAST_IDX    = IDX_W'(NUM_CHILDREN - 1);
    localparam logic [CNT_W-1:0]        TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

    state_t                  state_q, state_d;
    logic                    up_ready_q, up_ready_d;
    logic                    up_done_q, up_done_d;
    logic                    up_err_q, up_err_d;
    logic [NUM_CHILDREN-1:0] fail_mask_q, fail_mask_d;
    logic [NUM_CHILDREN-1:0] dn_valid_q, dn_valid_d;
    logic [DATA_W-1:0]       dn_data_q, dn_data_d;
    logic [NUM_CHILDREN-1:0] pending_q, pending_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [NUM_CHILDREN-1:0] vld_left;
    logic [NUM_CHILDREN-1:0] pend_left;
    logic                    timeout_hit;

    // Single-bit mask selecting child i.
    function automatic logic [NUM_CHILDREN-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [NUM_CHILDREN-1:0] r;
        for (int k = 0; k < NUM_CHILDREN; k++) begin
            r[k] = (k == int'(i));
        end
        return r;
    endfunction

    // Children with an index above i: the ones a sequential run has not reached yet.
    function automatic logic [NUM_CHILDREN-1:0] above(input logic [IDX_W-1:0] i);
        logic [NUM_CHILDREN-1:0] r;
        for (int k = 0; k < NUM_CHILDREN; k++) begin
            r[k] = (k > int'(i));
        end
        return r;
    endfunction

    // A valid drops once its ready is sampled; a pending bit drops on done,
    // independently of whether that child's valid has been accepted yet.
    assign vld_left    = dn_valid_q & ~bus.dn_ready;
    assign pend_left   = pending_q & ~bus.dn_done;
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == TIMEOUT_VAL);

    // Next-state and next-output logic for the transaction sequencer.
    always_comb begin
        state_d     = state_q;
        up_done_d   = 1'b0;
        up_err_d    = 1'b0;
        fail_mask_d = fail_mask_q;
        dn_valid_d  = dn_valid_q;
        dn_data_d   = dn_data_q;
        pending_d   = pending_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.up_valid) begin
                    dn_data_d   = bus.up_data;
                    fail_mask_d = '0;
                    idx_d       = '0;
                    cnt_d       = '0;
                    pending_d   = (SEQ_MODE != 0) ? onehot(IDX_W'(0)) : ALL_ONES;
                    dn_valid_d  = (SEQ_MODE != 0) ? onehot(IDX_W'(0)) : ALL_ONES;
                    state_d     = S_ISSUE;
                end
            end

            S_ISSUE, S_WAIT: begin
                if (timeout_hit) begin
                    fail_mask_d = pending_q | ((SEQ_MODE != 0) ? above(idx_q) : '0);
                    dn_valid_d  = '0;
                    up_done_d   = 1'b1;
                    up_err_d    = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    dn_valid_d = vld_left;
                    pending_d  = pend_left;
                    cnt_d      = cnt_q + 1'b1;
                    if (vld_left == '0 && pend_left == '0) begin
                        // Current batch fully accepted and completed.
                        if (SEQ_MODE == 0 || idx_q == LAST_IDX) begin
                            up_done_d = 1'b1;
                            state_d   = S_RESP;
                        end else begin
                            idx_d      = idx_q + 1'b1;
                            pending_d  = onehot(idx_q + 1'b1);
                            dn_valid_d = onehot(idx_q + 1'b1);
                            cnt_d      = '0;
                            state_d    = S_ISSUE;
                        end
                    end else if (vld_left == '0) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        up_ready_d = (state_d == S_IDLE);
    end

    // State and output registers; reset aborts any transaction silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            up_ready_q  <= 1'b1;
            up_done_q   <= 1'b0;
            up_err_q    <= 1'b0;
            fail_mask_q <= '0;
            dn_valid_q  <= '0;
            dn_data_q   <= '0;
            pending_q   <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            up_ready_q  <= up_ready_d;
            up_done_q   <= up_done_d;
            up_err_q    <= up_err_d;
            fail_mask_q <= fail_mask_d;
            dn_valid_q  <= dn_valid_d;
            dn_data_q   <= dn_data_d;
            pending_q   <= pending_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.up_ready  = up_ready_q;
    assign bus.up_done   = up_done_q;
    assign bus.up_err    = up_err_q;
    assign bus.fail_mask = fail_mask_q;
    assign bus.dn_valid  = dn_valid_q;
    assign bus.dn_data   = dn_data_q;

endmodule

// File: tb/tb_hier_fanout_node.sv
// Bench for hier_fanout_node: a 10-child broadcast node and a 4-child
// sequential node, both with a 20-cycle timeout, driven by directed scripts.
module tb_hier_fanout_node;

    localparam int TOUT = 20;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hier_fanout_if #(.NUM_CHILDREN(10), .DATA_W(8)) bif ();
    hier_fanout_if #(.NUM_CHILDREN(4),  .DATA_W(8)) sif ();

    hier_fanout_node #(
        .NUM_CHILDREN(10), .DATA_W(8), .SEQ_MODE(0), .TIMEOUT_CYC(TOUT), .CNT_W(8)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    hier_fanout_node #(
        .NUM_CHILDREN(4), .DATA_W(8), .SEQ_MODE(1), .TIMEOUT_CYC(TOUT), .CNT_W(8)
    ) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- reference model (unit 0 = broadcast, unit 1 = sequential)
    // phase: 0 idle, 1 busy (issuing or waiting), 2 responding
    int          m_ph   [2];
    int          m_cur  [2];
    int          m_age  [2];
    logic [31:0] m_vld  [2];
    logic [31:0] m_pend [2];
    logic [31:0] m_fail [2];
    logic        m_done [2];
    logic        m_err  [2];
    logic [7:0]  m_data [2];

    function automatic int nch(input int u);
        return (u == 0) ? 10 : 4;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_ph[u] = 0; m_cur[u] = 0; m_age[u] = 0;
            m_vld[u] = '0; m_pend[u] = '0; m_fail[u] = '0;
            m_done[u] = 1'b0; m_err[u] = 1'b0; m_data[u] = '0;
        end
    endtask

    task automatic model_step(input int u, input logic uv, input logic [7:0] ud,
                              input logic [31:0] rdy, input logic [31:0] dn);
        logic [31:0] all;
        logic        sq;
        sq  = (u == 1);
        all = (32'd1 << nch(u)) - 32'd1;
        if (m_ph[u] == 0) begin
            if (uv) begin
                m_data[u] = ud;
                m_fail[u] = '0;
                m_cur[u]  = 0;
                m_age[u]  = 0;
                m_pend[u] = sq ? 32'd1 : all;
                m_vld[u]  = m_pend[u];
                m_ph[u]   = 1;
            end
        end else if (m_ph[u] == 1) begin
            if (m_age[u] == TOUT) begin
                m_fail[u] = m_pend[u] | (sq ? (all & ~((32'd2 << m_cur[u]) - 32'd1)) : 32'd0);
                m_vld[u]  = '0;
                m_done[u] = 1'b1;
                m_err[u]  = 1'b1;
                m_ph[u]   = 2;
            end else begin
                m_vld[u]  = m_vld[u] & ~rdy;
                m_pend[u] = m_pend[u] & ~dn;
                m_age[u]  = m_age[u] + 1;
                if (m_vld[u] == 0 && m_pend[u] == 0) begin
                    if (!sq || m_cur[u] == nch(u) - 1) begin
                        m_done[u] = 1'b1;
                        m_ph[u]   = 2;
                    end else begin
                        m_cur[u]  = m_cur[u] + 1;
                        m_pend[u] = 32'd1 << m_cur[u];
                        m_vld[u]  = m_pend[u];
                        m_age[u]  = 0;
                    end
                end
            end
        end else begin
            m_done[u] = 1'b0;
            m_err[u]  = 1'b0;
            m_ph[u]   = 0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else begin
                model_step(0, bif.up_valid, bif.up_data, 32'(bif.dn_ready), 32'(bif.dn_done));
                model_step(1, sif.up_valid, sif.up_data, 32'(sif.dn_ready), 32'(sif.dn_done));
            end
        end
    end

    function automatic logic [74:0] exp_vec(input int u);
        return {m_ph[u] == 0, m_done[u], m_err[u], m_fail[u], m_vld[u], m_data[u]};
    endfunction

    // ---------------- checking helpers
    task automatic check(input string nm, input logic [74:0] act, input logic [74:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("b_cycle", {bif.up_ready, bif.up_done, bif.up_err, 32'(bif.fail_mask),
                          32'(bif.dn_valid), bif.dn_data}, exp_vec(0));
        check("s_cycle", {sif.up_ready, sif.up_done, sif.up_err, 32'(sif.fail_mask),
                          32'(sif.dn_valid), sif.dn_data}, exp_vec(1));
    endtask

    // One clock: compare on the falling edge, then land just after the rising edge.
    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    // ---------------- broadcast script runner
    logic [9:0] rt     [0:47];
    logic [9:0] dt     [0:47];
    logic [9:0] seen_v [0:47];
    logic [9:0] rec_fm;
    logic       rec_err;

    task automatic clr_tab();
        for (int i = 0; i < 48; i++) begin
            rt[i] = '0; dt[i] = '0; seen_v[i] = '0;
        end
    endtask

    // Cycle c means c clock edges after the accepting edge.
    task automatic run_b(input logic [7:0] d, input int ncyc,
                         output int first_done, output int ndone);
        bif.up_valid = 1'b1;
        bif.up_data  = d;
        tick();
        bif.up_valid = 1'b0;
        first_done = -1;
        ndone      = 0;
        for (int c = 1; c <= ncyc; c++) begin
            seen_v[c] = bif.dn_valid;
            if (bif.up_done) begin
                ndone++;
                if (first_done < 0) begin
                    first_done = c;
                    rec_fm     = bif.fail_mask;
                    rec_err    = bif.up_err;
                end
            end
            bif.dn_ready = rt[c];
            bif.dn_done  = dt[c];
            tick();
        end
        bif.dn_ready = '0;
        bif.dn_done  = '0;
    endtask

    int fd, nd, cyc;

    initial begin
        rst_n = 1'b0;
        bif.up_valid = 1'b0; bif.up_data = '0; bif.dn_ready = '0; bif.dn_done = '0;
        sif.up_valid = 1'b0; sif.up_data = '0; sif.dn_ready = '0; sif.dn_done = '0;
        rec_fm = '0; rec_err = 1'b0;
        clr_tab();
        tick();
        tick();
        check("reset_outs", {bif.up_ready, bif.up_done, bif.up_err, bif.fail_mask,
                             bif.dn_valid, bif.dn_data}, {1'b1, 1'b0, 1'b0, 10'h0, 10'h0, 8'h0});
        rst_n = 1'b1;
        tick();

        // Broadcast, all ready, every child done in cycle 5.
        clr_tab();
        for (int i = 0; i < 48; i++) rt[i] = 10'h3FF;
        dt[5] = 10'h3FF;
        run_b(8'hA5, 8, fd, nd);
        check("bc_valid_c1", 75'(seen_v[1]), 75'(10'h3FF));
        check("bc_valid_c2", 75'(seen_v[2]), 75'(10'h000));
        check("bc_data", 75'(bif.dn_data), 75'(8'hA5));
        check("bc_done_cyc", 75'(fd), 75'(6));
        check("bc_done_cnt", 75'(nd), 75'(1));
        check("bc_err", 75'(rec_err), 75'(0));

        // Staggered ready, same-cycle ready+done on child 2, spurious dones.
        clr_tab();
        rt[1] = 10'h003; rt[2] = 10'h004; rt[3] = 10'h3F8;
        dt[2] = 10'h005; dt[3] = 10'h001; dt[4] = 10'h1FA; dt[5] = 10'h005; dt[6] = 10'h200;
        run_b(8'hC3, 12, fd, nd);
        check("stag_valid_c2", 75'(seen_v[2]), 75'(10'h3FC));
        check("stag_valid_c3", 75'(seen_v[3]), 75'(10'h3F8));
        check("stag_done_cyc", 75'(fd), 75'(7));
        check("stag_done_cnt", 75'(nd), 75'(1));

        // Timeout: children 3 and 7 never complete.
        clr_tab();
        for (int i = 0; i < 48; i++) rt[i] = 10'h3FF;
        dt[3] = 10'h377;
        run_b(8'h5A, 30, fd, nd);
        check("to_done_cyc", 75'(fd), 75'(22));
        check("to_err", 75'(rec_err), 75'(1));
        check("to_fail_mask", 75'(rec_fm), 75'(10'h088));
        check("to_valid_off", 75'(seen_v[22]), 75'(10'h000));
        check("to_mask_held", 75'(bif.fail_mask), 75'(10'h088));

        // Back-to-back with up_valid held across completion.
        bif.up_valid = 1'b1; bif.up_data = 8'h11; bif.dn_ready = '1;
        tick();
        check("b2b_mask_clr", 75'(bif.fail_mask), 75'(0));
        bif.up_data = 8'h22;
        tick();
        bif.dn_done = '1;
        tick();
        check("b2b_done1", 75'(bif.up_done), 75'(1));
        bif.dn_done = '0;
        tick();
        check("b2b_idle_rdy", 75'(bif.up_ready), 75'(1));
        tick();
        check("b2b_second", {bif.dn_data, bif.dn_valid}, {8'h22, 10'h3FF});
        bif.up_valid = 1'b0;
        bif.dn_done  = '1;
        tick();
        check("b2b_done2", 75'(bif.up_done), 75'(1));
        bif.dn_done = '0; bif.dn_ready = '0;
        tick();
        tick();

        // Sequential: ready one cycle after valid, done two cycles after ready.
        sif.up_valid = 1'b1; sif.up_data = 8'h3C;
        tick();
        sif.up_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("seq_onehot", 75'(sif.dn_valid), 75'(4'b0001 << c));
            tick();
            sif.dn_ready = 4'(4'b0001 << c);
            tick();
            sif.dn_ready = '0;
            tick();
            sif.dn_done = 4'(4'b0001 << c);
            tick();
            sif.dn_done = '0;
        end
        check("seq_done", {sif.up_done, sif.up_err}, 75'(2'b10));
        check("seq_data", 75'(sif.dn_data), 75'(8'h3C));
        tick();
        tick();

        // Sequential timeout: child 1 never accepts.
        sif.up_valid = 1'b1; sif.up_data = 8'h77;
        tick();
        sif.up_valid = 1'b0;
        sif.dn_ready = 4'b0001; sif.dn_done = 4'b0001;
        tick();
        sif.dn_ready = '0; sif.dn_done = '0;
        check("seqto_next", 75'(sif.dn_valid), 75'(4'b0010));
        cyc = 2;
        while (!sif.up_done && cyc < 40) begin
            tick();
            cyc++;
        end
        check("seqto_cyc", 75'(cyc), 75'(23));
        check("seqto_mask", {sif.up_err, sif.fail_mask}, {1'b1, 4'b1110});
        tick();
        tick();

        // Reset in the middle of a wait, then a clean transaction.
        bif.up_valid = 1'b1; bif.up_data = 8'h99; bif.dn_ready = '1;
        tick();
        bif.up_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid", {bif.up_ready, bif.up_done, bif.up_err, bif.fail_mask,
                          bif.dn_valid, bif.dn_data}, {1'b1, 1'b0, 1'b0, 10'h0, 10'h0, 8'h0});
        bif.dn_ready = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_rdy", 75'(bif.up_ready), 75'(1));
        clr_tab();
        for (int i = 0; i < 48; i++) rt[i] = 10'h3FF;
        dt[2] = 10'h3FF;
        run_b(8'h42, 6, fd, nd);
        check("rst_after_done", {8'(fd), 8'(nd), 7'(rec_err)}, {8'd3, 8'd1, 7'd0});
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hier_fanout_node.md
Name: hier_fanout_node

Overview:
Parametrised hierarchy node that takes one command from its parent and distributes it to NUM_CHILDREN child instances.
- Broadcast mode sends the command to all children at once; sequential mode sends it to one child at a time, in index order.
- Collects per-child completions and returns a single done/error to the parent.
- Nests recursively to build deep, wide generated hierarchies with real transaction traffic instead of empty instance trees.

Parameters:
NUM_CHILDREN, 10, number of child ports (1..32)
DATA_W, 8, command payload width
SEQ_MODE, 0, 0 = broadcast to all children, 1 = sequential by ascending index
TIMEOUT_CYC, 255, max cycles spent in WAIT before abort; 0 disables timeout
CNT_W, 8, timeout counter width; must be at least clog2(TIMEOUT_CYC+1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
up_valid  in  1  parent command valid
up_ready  out  1  node can accept a command
up_data  in  DATA_W  parent command payload
up_done  out  1  one-cycle pulse, transaction finished
up_err  out  1  qualifies up_done: timeout occurred
fail_mask  out  NUM_CHILDREN  children still pending at timeout; held until next accept
dn_valid  out  NUM_CHILDREN  per-child command valid
dn_data  out  DATA_W  registered command payload, shared by all children
dn_ready  in  NUM_CHILDREN  per-child command accept
dn_done  in  NUM_CHILDREN  per-child completion pulse

Behaviour:
- Reset (async assert, sync release): state=IDLE, up_ready=1, up_done=0, up_err=0, fail_mask=0, dn_valid=0, dn_data=0, internal pending mask=0, index=0, counter=0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - up_ready=1.
  - On up_valid&up_ready: latch up_data into dn_data, clear fail_mask, go to ISSUE.
  - Broadcast: pending=all ones.
  - Sequential: pending=bit0, index=0.
- ISSUE:
  - dn_valid asserted, starting the cycle after accept.
  - Broadcast: dn_valid=pending-issue mask; each bit clears individually in the cycle after its dn_ready is sampled high.
  - Sequential: only dn_valid[index] is high.
  - Go to WAIT once all issued valids have been accepted.
- WAIT:
  - dn_done[i] clears pending[i].
  - dn_done on a non-pending bit is ignored.
  - dn_done may arrive in the same cycle as, or before, the matching dn_ready; it is still counted, but that child's valid stays up until its ready is seen.
  - Broadcast: when pending becomes 0, go to RESP.
  - Sequential: on done of child index, if index==NUM_CHILDREN-1 go to RESP; otherwise increment index, set pending to that bit, return to ISSUE.
- Timeout:
  - Counter resets on every entry to ISSUE and counts every cycle in ISSUE and WAIT.
  - When counter==TIMEOUT_CYC (and TIMEOUT_CYC≠0): fail_mask=pending, dn_valid forced to 0, go to RESP with error flagged.
  - In sequential mode, remaining unissued children are also set in fail_mask.
- RESP:
  - up_done=1 for exactly one cycle; up_err=1 in the same cycle if a timeout occurred.
  - Next state IDLE.
  - Latency from the last dn_done to up_done is exactly 1 cycle.
- up_ready=0 in every state other than IDLE; the parent must hold up_valid and up_data until accepted.
- dn_data is stable for the whole transaction.
- Reset asserted mid-transaction aborts immediately with all outputs at reset values; no up_done is generated.
- NUM_CHILDREN=1: both modes behave identically.

Test Plan:
1. Broadcast, NUM_CHILDREN=10: up_data=8'hA5, all dn_ready=1, dn_done all at cycle 5 -> dn_valid=10'h3FF for 1 cycle, dn_data=A5, up_done at cycle 6, up_err=0.
2. Sequential, NUM_CHILDREN=4: each child readies after 1 cycle and dones 2 cycles later -> dn_valid one-hot 0001,0010,0100,1000 in order, one up_done after child 3 done.
3. Timeout, TIMEOUT_CYC=20, broadcast: children 3 and 7 never done -> after 20 cycles up_done=1, up_err=1, fail_mask=10'h088, dn_valid=0.
4. Staggered ready with a same-cycle ready+done on child 2, plus a spurious dn_done on an already-finished child -> no double count, up_done exactly once.
5. Reset asserted mid-WAIT -> all outputs at reset values immediately, up_ready=1 after release; the next command completes normally.
6. Back-to-back: up_valid held high across completion -> second command accepted the cycle after RESP (IDLE), fail_mask cleared.
